// File: rtl/seven_bit_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : seven_bit_adder_ctrl
// Brief   : Debounced push-button sequencer that loads two 7-bit operands
//           nibble-by-nibble and latches the external adder's result.
// Revision: 1.0 - initial release
// ============================================================================
module seven_bit_adder_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PB1,
    input  logic       PB2,
    input  logic       PB3,
    input  logic       PB4,
    input  logic [3:0] Y,
    input  logic [6:0] add_sum,
    input  logic       add_carry,
    output logic [6:0] op_a,
    output logic [6:0] op_b,
    output logic [6:0] sum,
    output logic       carry,
    output logic       done,
    output logic       seq_err,
    output logic [2:0] state
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_A_LO = 3'd0,
        S_WAIT_A_HI = 3'd1,
        S_WAIT_B_LO = 3'd2,
        S_WAIT_B_HI = 3'd3,
        S_CAPTURE   = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    logic [3:0] w_pb;
    logic [3:0] w_acc;

    assign w_pb = {PB4, PB3, PB2, PB1};

    // Per button: two-flop synchroniser, stability counter, rising-edge pulse.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_button
            logic               r_sync1;
            logic               r_sync2;
            logic               r_db;
            logic               r_db_d;
            logic [c_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                    r_db    <= 1'b0;
                    r_db_d  <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_sync1 <= w_pb[gi];
                    r_sync2 <= r_sync1;
                    r_db_d  <= r_db;
                    if (r_sync2 != r_db) begin
                        if (r_cnt == c_CNT_MAX) begin
                            r_db  <= r_sync2;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            assign w_acc[gi] = r_db & ~r_db_d;
        end
    endgenerate

    state_t     r_state;
    state_t     w_state_nxt;
    logic [6:0] r_op_a;
    logic [6:0] w_op_a_nxt;
    logic [6:0] r_op_b;
    logic [6:0] w_op_b_nxt;
    logic [6:0] r_sum;
    logic [6:0] w_sum_nxt;
    logic       r_carry;
    logic       w_carry_nxt;
    logic       r_seq_err;
    logic       w_seq_err_nxt;
    logic [3:0] w_expect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_WAIT_A_LO;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_sum     <= '0;
            r_carry   <= 1'b0;
            r_seq_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_op_a    <= w_op_a_nxt;
            r_op_b    <= w_op_b_nxt;
            r_sum     <= w_sum_nxt;
            r_carry   <= w_carry_nxt;
            r_seq_err <= w_seq_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_op_a_nxt    = r_op_a;
        w_op_b_nxt    = r_op_b;
        w_sum_nxt     = r_sum;
        w_carry_nxt   = r_carry;
        w_seq_err_nxt = r_seq_err;
        w_expect      = 4'b0000;

        case (r_state)
            S_WAIT_A_HI: w_expect = 4'b0010;
            S_WAIT_B_LO: w_expect = 4'b0100;
            S_WAIT_B_HI: w_expect = 4'b1000;
            default:     w_expect = 4'b0000;
        endcase

        if (r_state == S_CAPTURE) begin
            w_state_nxt = S_DONE;
            w_sum_nxt   = add_sum;
            w_carry_nxt = add_carry;
        end else if (r_state > S_DONE) begin
            w_state_nxt = S_WAIT_A_LO;
        end else if (w_acc[0]) begin
            // PB1 restarts from anywhere and overrides every other press
            w_op_a_nxt[3:0] = Y;
            w_state_nxt     = S_WAIT_A_HI;
            w_seq_err_nxt   = 1'b0;
        end else begin
            if (|(w_acc & w_expect)) begin
                case (r_state)
                    S_WAIT_A_HI: begin
                        w_op_a_nxt[6:4] = Y[2:0];
                        w_state_nxt     = S_WAIT_B_LO;
                    end
                    S_WAIT_B_LO: begin
                        w_op_b_nxt[3:0] = Y;
                        w_state_nxt     = S_WAIT_B_HI;
                    end
                    S_WAIT_B_HI: begin
                        w_op_b_nxt[6:4] = Y[2:0];
                        w_state_nxt     = S_CAPTURE;
                    end
                    default: w_state_nxt = r_state;
                endcase
            end
            if (|(w_acc[3:1] & ~w_expect[3:1])) begin
                w_seq_err_nxt = 1'b1;
            end
        end
    end

    assign op_a    = r_op_a;
    assign op_b    = r_op_b;
    assign sum     = r_sum;
    assign carry   = r_carry;
    assign seq_err = r_seq_err;
    assign done    = (r_state == S_DONE);
    assign state   = r_state;

endmodule
`default_nettype wire

// File: doc/seven_bit_adder_ctrl.md
# seven_bit_adder_ctrl

Operand-sequencing controller for the 7-bit adder datapath on the lab board. It synchronises and debounces the four push buttons and loads two 7-bit operands nibble-by-nibble from the 4-bit switch bus `Y`. It then presents the operands to the external combinational `seven_bit_adder` and latches its sum and carry for display. The block sits between the board I/O and the adder, and owns all sequencing and error flagging.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required before a synchronised button level is accepted; legal range ≥1.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `PB1`..`PB4`  in  1 each  raw, asynchronous push buttons, active-high.
- `Y`  in  4  switch bus; sampled only on an accepted press.
- `add_sum`  in  7  sum from external adder.
- `add_carry`  in  1  carry from external adder.
- `op_a`  out  7  operand A to adder.
- `op_b`  out  7  operand B to adder.
- `sum`  out  7  latched result.
- `carry`  out  1  latched carry.
- `done`  out  1  result valid.
- `seq_err`  out  1  sticky out-of-order press flag.
- `state`  out  3  current FSM state, for LEDs and debug.

## Operation
- Button path, per button: 2-flop synchroniser, then debouncer. The debounced level changes only after the synchronised input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. A rising edge of the debounced level produces a 1-cycle `acc_PBn` pulse.
- Operand mapping:
  - PB1 loads `op_a[3:0]=Y`.
  - PB2 loads `op_a[6:4]=Y[2:0]`.
  - PB3 loads `op_b[3:0]=Y`.
  - PB4 loads `op_b[6:4]=Y[2:0]`.
  - `Y[3]` is ignored on the high-part loads.
- State encoding: WAIT_A_LO=0, WAIT_A_HI=1, WAIT_B_LO=2, WAIT_B_HI=3, CAPTURE=4, DONE=5. Codes 6 and 7 are illegal and go to WAIT_A_LO.
- Transitions:
  - WAIT_A_LO –acc_PB1→ WAIT_A_HI
  - WAIT_A_HI –acc_PB2→ WAIT_B_LO
  - WAIT_B_LO –acc_PB3→ WAIT_B_HI
  - WAIT_B_HI –acc_PB4→ CAPTURE
  - CAPTURE → DONE unconditionally, after one cycle.
- CAPTURE latches `sum<=add_sum` and `carry<=add_carry`. The operands have been stable since the PB4 load, so the adder output has settled.
- DONE: `done=1`. `sum`/`carry` hold until the next CAPTURE.
- PB1 restart: `acc_PB1` in any state except CAPTURE loads `op_a[3:0]`, goes to WAIT_A_HI, clears `done` and `seq_err`. `op_b` is retained until overwritten.
- Out-of-order press: an accepted PB2/PB3/PB4 that is not the expected button sets `seq_err=1`. There is no state or operand change. Any press during CAPTURE is ignored.
- Simultaneous pulses in one cycle: PB1 has highest priority and acts alone. Otherwise the expected button acts, and any other pulse present also sets `seq_err`.
- Arithmetic is performed externally. The controller does no width conversion beyond the nibble packing above.

## Timing
- Reset (asynchronous, immediate):
  - `op_a`, `op_b`, `sum` = 0; `carry`, `done`, `seq_err` = 0.
  - `state` = WAIT_A_LO.
  - Synchronisers, debounce counters and debounced levels = 0.
- Raw press to `acc_PBn` pulse: 2 synchroniser cycles + `DEBOUNCE_CYCLES` + 1 edge-detect cycle. The operand register and state update on the clock edge ending the pulse cycle.
- PB4 accept to `done=1`: 2 cycles (WAIT_B_HI→CAPTURE, CAPTURE→DONE).
- Release needs no action. A press shorter than `DEBOUNCE_CYCLES` stable cycles is never accepted.
- Holding a button produces exactly one pulse. A button held through reset deassertion produces one pulse after the debounce interval.
- Reset mid-sequence discards all partial operands and results.

## Test plan
- Run all scenarios with `DEBOUNCE_CYCLES=4`.
- Normal add: PB1 Y=0101, PB2 Y=0010, PB3 Y=1010, PB4 Y=0101 → `op_a`=0100101, `op_b`=1011010, `sum`=1111111, `carry`=0, `done`=1 exactly 2 cycles after PB4 accept, `state`=5.
- Overflow: A=127 (PB1 Y=1111, PB2 Y=0111), B=1 (PB3 Y=0001, PB4 Y=0000) → `sum`=0000000, `carry`=1.
- Bounce: PB1 toggled 1,0,1,0 at 1-cycle intervals, then held 10 cycles → exactly one accept. A 3-cycle glitch on PB2 → no accept.
- Out-of-order: in WAIT_A_LO press PB3 → `seq_err`=1, `state`=0, `op_b` unchanged. Then PB1 → `seq_err`=0, `state`=1.
- Priority and restart: PB1 and PB2 accepted in the same cycle in WAIT_A_HI → PB1 acts, `state`=1. In DONE press PB1 Y=0011 → `done`=0, `op_a[3:0]`=0011, previous `sum` held.
- Reset mid-op: assert `rst` in WAIT_B_HI → all outputs 0 and `state`=0 immediately, without waiting for a clock edge.
